// File: rtl/alu_sequencer.sv
// alu_sequencer: execute-stage sequencer wrapped around an external 32-bit
// combinational ALU. It registers operands into the ALU and waits a fixed
// settle window before capturing the result and flags. It also implements
// iterative 32-bit divide/remainder (op[4:0] = 19..22) as a restoring divider.
module alu_sequencer #(
    parameter int SETTLE = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  op,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        carry,
    output logic        zero,
    output logic        negative,
    output logic        div_by_zero,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [7:0]  alu_op,
    output logic        alu_carry_in,
    input  logic [31:0] alu_c,
    input  logic        alu_carry_out,
    input  logic        alu_is_zero,
    input  logic        alu_is_negative
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DIV    = 2'd2,
        ST_FIX    = 2'd3
    } state_t;

    // Counter reload value: capture happens on the edge where it reads zero.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    localparam logic [4:0] OP_DIVU = 5'd19;
    localparam logic [4:0] OP_DIVS = 5'd20;
    localparam logic [4:0] OP_REMU = 5'd21;
    localparam logic [4:0] OP_REMS = 5'd22;

    // Two's-complement magnitude, applied only when the op is signed.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic en);
        logic [31:0] m;
        if (en && v[31]) begin
            m = ~v + 32'd1;
        end else begin
            m = v;
        end
        return m;
    endfunction

    // Conditional two's-complement negation used for the final sign fix-up.
    function automatic logic [31:0] apply_sign(input logic [31:0] v, input logic neg);
        logic [31:0] s;
        if (neg) begin
            s = ~v + 32'd1;
        end else begin
            s = v;
        end
        return s;
    endfunction

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic [4:0]  bit_cnt_r;
    logic [31:0] quo_r;
    logic [31:0] rem_r;
    logic [31:0] divisor_r;
    logic        qsign_r;
    logic        rsign_r;
    logic        rem_op_r;
    logic        b_zero_r;

    logic        busy_r;
    logic        done_r;
    logic [31:0] result_r;
    logic        carry_r;
    logic        zero_r;
    logic        negative_r;
    logic        div_by_zero_r;
    logic [31:0] alu_a_r;
    logic [31:0] alu_b_r;
    logic [7:0]  alu_op_r;
    logic        alu_carry_in_r;

    logic        is_div_s;
    logic        is_signed_s;
    logic        is_rem_s;
    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [32:0] shifted_s;
    logic        q_bit_s;
    logic [31:0] next_rem_s;
    logic [31:0] div_result_s;

    // Decode the incoming op and form operand magnitudes for a divide launch.
    always_comb begin
        is_div_s    = 1'b0;
        is_signed_s = 1'b0;
        is_rem_s    = 1'b0;
        case (op[4:0])
            OP_DIVU: begin
                is_div_s = 1'b1;
            end
            OP_DIVS: begin
                is_div_s    = 1'b1;
                is_signed_s = 1'b1;
            end
            OP_REMU: begin
                is_div_s = 1'b1;
                is_rem_s = 1'b1;
            end
            OP_REMS: begin
                is_div_s    = 1'b1;
                is_signed_s = 1'b1;
                is_rem_s    = 1'b1;
            end
            default: begin
                is_div_s    = 1'b0;
                is_signed_s = 1'b0;
                is_rem_s    = 1'b0;
            end
        endcase
        a_mag_s = magnitude(a_in, is_signed_s);
        b_mag_s = magnitude(b_in, is_signed_s);
    end

    // One restoring-division step: shift in the next dividend bit, trial-subtract.
    always_comb begin
        shifted_s  = {1'b0, rem_r} << 1;
        shifted_s[0] = quo_r[31];
        q_bit_s    = (shifted_s >= {1'b0, divisor_r});
        if (q_bit_s) begin
            next_rem_s = shifted_s[31:0] - divisor_r;
        end else begin
            next_rem_s = shifted_s[31:0];
        end
    end

    // Final divide result: divide-by-zero values, or sign-corrected quotient/remainder.
    always_comb begin
        div_result_s = 32'd0;
        if (b_zero_r) begin
            if (rem_op_r) begin
                div_result_s = alu_a_r;
            end else begin
                div_result_s = 32'hFFFF_FFFF;
            end
        end else if (rem_op_r) begin
            div_result_s = apply_sign(rem_r, rsign_r);
        end else begin
            div_result_s = apply_sign(quo_r, qsign_r);
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            cnt_r          <= 4'd0;
            bit_cnt_r      <= 5'd0;
            quo_r          <= 32'd0;
            rem_r          <= 32'd0;
            divisor_r      <= 32'd0;
            qsign_r        <= 1'b0;
            rsign_r        <= 1'b0;
            rem_op_r       <= 1'b0;
            b_zero_r       <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            result_r       <= 32'd0;
            carry_r        <= 1'b0;
            zero_r         <= 1'b0;
            negative_r     <= 1'b0;
            div_by_zero_r  <= 1'b0;
            alu_a_r        <= 32'd0;
            alu_b_r        <= 32'd0;
            alu_op_r       <= 8'd0;
            alu_carry_in_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        alu_a_r        <= a_in;
                        alu_b_r        <= b_in;
                        alu_op_r       <= op;
                        alu_carry_in_r <= carry_r;
                        busy_r         <= 1'b1;
                        if (is_div_s) begin
                            state_r   <= ST_DIV;
                            quo_r     <= a_mag_s;
                            rem_r     <= 32'd0;
                            divisor_r <= b_mag_s;
                            bit_cnt_r <= 5'd0;
                            qsign_r   <= is_signed_s & (a_in[31] ^ b_in[31]);
                            rsign_r   <= is_signed_s & a_in[31];
                            rem_op_r  <= is_rem_s;
                            b_zero_r  <= (b_in == 32'd0);
                        end else begin
                            state_r <= ST_SETTLE;
                            cnt_r   <= SETTLE_LOAD;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_r == 4'd0) begin
                        result_r      <= alu_c;
                        carry_r       <= alu_carry_out;
                        zero_r        <= alu_is_zero;
                        negative_r    <= alu_is_negative;
                        div_by_zero_r <= 1'b0;
                        done_r        <= 1'b1;
                        busy_r        <= 1'b0;
                        state_r       <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_DIV: begin
                    if (b_zero_r) begin
                        state_r <= ST_FIX;
                    end else begin
                        rem_r <= next_rem_s;
                        quo_r <= {quo_r[30:0], q_bit_s};
                        if (bit_cnt_r == 5'd31) begin
                            state_r <= ST_FIX;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end
                    end
                end
                ST_FIX: begin
                    result_r      <= div_result_s;
                    carry_r       <= 1'b0;
                    zero_r        <= (div_result_s == 32'd0);
                    negative_r    <= div_result_s[31];
                    div_by_zero_r <= b_zero_r;
                    done_r        <= 1'b1;
                    busy_r        <= 1'b0;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign result       = result_r;
    assign carry        = carry_r;
    assign zero         = zero_r;
    assign negative     = negative_r;
    assign div_by_zero  = div_by_zero_r;
    assign alu_a        = alu_a_r;
    assign alu_b        = alu_b_r;
    assign alu_op       = alu_op_r;
    assign alu_carry_in = alu_carry_in_r;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Execute-stage sequencer directly upstream of the 32-bit combinational ALU, and the consumer of its outputs.
- Registers operands, op and carry-in into the ALU.
- Holds them stable for a multicycle settle window, then captures the ALU result and flags into an architectural flag register.
- Adds iterative 32-bit divide/remainder ops (op[4:0] 19..22), which the ALU lacks.
- The CPU core drives it with a start/done handshake.

Parameters:
SETTLE, 2, cycles ALU inputs are held before result capture; legal range 1..15.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  8  operation code; op[4:0] selects, op[7:5] passed through
a_in  input  32  operand A
b_in  input  32  operand B
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse: result/flags updated this cycle
result  output  32  last captured result, held until next capture
carry  output  1  carry flag
zero  output  1  zero flag
negative  output  1  negative flag
div_by_zero  output  1  set by divide ops with b=0, cleared by any other capture
alu_a  output  32  registered operand A to ALU
alu_b  output  32  registered operand B to ALU
alu_op  output  8  registered op to ALU
alu_carry_in  output  1  registered copy of carry flag at start
alu_c  input  32  ALU result
alu_carry_out  input  1  ALU carry
alu_is_zero  input  1  ALU zero
alu_is_negative  input  1  ALU negative

Behaviour:
- Clocking: one clock, all state updates on the rising clk edge. Reset is synchronous and active-high.
- Reset: state IDLE, all outputs 0 (busy, done, result, flags, div_by_zero, alu_* registers). Reset mid-operation aborts it; no done is issued and flags are unchanged from their reset value of 0.
- States: IDLE, SETTLE, DIV, FIX.
- IDLE, start=1:
  - Latch a_in/b_in/op into alu_a/alu_b/alu_op, and carry into alu_carry_in.
  - busy goes high.
  - op[4:0] in 19..22 -> DIV; else -> SETTLE with counter=SETTLE-1.
- start outside IDLE is ignored (no queueing).
- SETTLE:
  - Counter decrements each edge.
  - On the edge where the counter is 0: result<=alu_c, carry<=alu_carry_out, zero<=alu_is_zero, negative<=alu_is_negative, div_by_zero<=0, done<=1, busy<=0, -> IDLE.
  - Latency: done is high in the cycle following the SETTLE-th edge after the sampling edge (SETTLE=2: edges 0,1,2 -> done after edge 2).
- Divide ops: 19 divu, 20 divs (quotient); 21 remu, 22 rems (remainder).
- DIV, entered with b≠0:
  - Signed ops take magnitudes of a and b, and record qsign=a[31]^b[31] and rsign=a[31].
  - Restoring division, 1 quotient bit per edge, MSB first, 32 edges, 33-bit partial remainder.
  - Then FIX (1 edge): apply signs (quotient negated if qsign, remainder negated if rsign) and capture.
  - Latency: done after edge 33.
- DIV, entered with b=0: next edge goes straight to FIX. Quotient=FFFFFFFF, remainder=a, div_by_zero=1, done after edge 2.
- 0x80000000 / FFFFFFFF (divs): quotient 0x80000000, remainder 0, no trap.
- Divide flag capture: carry<=0, zero<=(result==0), negative<=result[31].
- done is exactly one cycle wide. busy and done are never high together. A new start may be sampled in the done cycle.
- alu_* registers hold their value after completion; they change only on accepted start.

Test Plan:
- Add: reset; start op=0 a=5 b=7 (SETTLE=2) -> done after edge 2, result=12, carry=0, zero=0, negative=0; busy high during edges 0..1.
- Carry chain: op=13 a=1 -> result=0, carry=1, zero=1. Then op=1 a=1 b=1 -> alu_carry_in=1, result=3, carry=0.
- Unsigned divide: divu 100/7 -> result=14, done exactly 33 edges after start edge. remu 100/7 -> result=2.
- Signed divide: divs -7/2 -> FFFFFFFD, negative=1. rems -7/2 -> FFFFFFFF. divs 80000000/FFFFFFFF -> 80000000.
- Divide by zero: divu 5/0 -> FFFFFFFF, div_by_zero=1, done after 2 edges. rems 5/0 -> 5. A following add clears div_by_zero.
- Busy/reset: start during DIV iteration 5 is ignored and the original result completes. Reset at iteration 10 -> busy=0, no done, result=0, all flags 0.
